// File: rtl/stepper_sequencer.sv
// stepper_sequencer: command-driven full-step two-phase coil sequencer with position tracking
module stepper_sequencer #(
    parameter int STEP_DIV = 50000,
    parameter bit HOLD_EN  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_dir,
    input  logic [15:0] cmd_steps,
    input  logic        cmd_abort,
    output logic [3:0]  coils,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] steps_left,
    output logic [15:0] position
);
    localparam int DW = $clog2(STEP_DIV);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [1:0]      phase, phase_n;
    logic [DW-1:0]   div, div_n;
    logic            dir, dir_n;
    logic            armed, armed_n;
    logic            aborted_n;
    logic [15:0]     steps_n, position_n;
    logic            tick;

    function automatic logic [3:0] pattern(input logic [1:0] p);
        return p == 2'd0 ? 4'b0011 : p == 2'd1 ? 4'b0110 : p == 2'd2 ? 4'b1100 : 4'b1001;
    endfunction

    assign tick = div == DW'(STEP_DIV - 1);

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        div_n      = div;
        dir_n      = dir;
        armed_n    = armed;
        aborted_n  = aborted;
        steps_n    = steps_left;
        position_n = position;
        unique case (state)
            IDLE: if (cmd_valid) begin
                armed_n   = 1'b1;
                aborted_n = 1'b0;
                dir_n     = cmd_dir;
                steps_n   = cmd_steps;
                div_n     = '0;
                state_n   = cmd_steps == 16'd0 ? DONE : RUN;
            end
            RUN: if (cmd_abort) begin
                aborted_n = 1'b1;
                state_n   = DONE;
            end else if (tick) begin
                phase_n    = dir ? phase + 2'd1 : phase - 2'd1;
                position_n = dir ? position + 16'd1 : position - 16'd1;
                steps_n    = steps_left - 16'd1;
                div_n      = '0;
                state_n    = steps_left == 16'd1 ? DONE : RUN;
            end else begin
                div_n = div + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Status and coil outputs are registered from next-state values so they align with the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            phase      <= 2'd0;
            div        <= '0;
            dir        <= 1'b0;
            armed      <= 1'b0;
            aborted    <= 1'b0;
            steps_left <= 16'd0;
            position   <= 16'd0;
            coils      <= 4'b0000;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            div        <= div_n;
            dir        <= dir_n;
            armed      <= armed_n;
            aborted    <= aborted_n;
            steps_left <= steps_n;
            position   <= position_n;
            coils      <= (state_n == RUN || (HOLD_EN && armed_n)) ? pattern(phase_n) : 4'b0000;
            cmd_ready  <= state_n == IDLE;
            busy       <= state_n == RUN;
            done       <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_stepper_sequencer.sv
// tb_stepper_sequencer: directed and randomized checks against a step-timeline reference model
module tb_stepper_sequencer;
    localparam int SD = 4;

    logic        clock = 1'b0, reset = 1'b0;
    logic        cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_abort = 1'b0;
    logic [15:0] cmd_steps = 16'd0;
    logic        rdy0, busy0, done0, ab0, rdy1, busy1, done1, ab1;
    logic [3:0]  coils0, coils1;
    logic [15:0] sl0, pos0, sl1, pos1;

    always #5 clock = ~clock;

    stepper_sequencer #(.STEP_DIV(SD), .HOLD_EN(1'b1)) u0 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy0),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_abort(cmd_abort), .coils(coils0),
        .busy(busy0), .done(done0), .aborted(ab0), .steps_left(sl0), .position(pos0));

    stepper_sequencer #(.STEP_DIV(SD), .HOLD_EN(1'b0)) u1 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(rdy1),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_abort(cmd_abort), .coils(coils1),
        .busy(busy1), .done(done1), .aborted(ab1), .steps_left(sl1), .position(pos1));

    int passed = 0, total = 0;
    // Model: mode 0 idle / 1 moving / 2 finishing; steps land every SD cycles after accept.
    int mode = 0, t = 0, ph = 0, rem = 0;
    logic [15:0] pos = 16'd0, p0;
    bit armed = 0, ab = 0, mdir = 0;
    logic [3:0] tbl [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mode = 0; t = 0; ph = 0; rem = 0; pos = 16'd0; armed = 0; ab = 0; mdir = 0;
    endtask

    task automatic model_edge();
        if (mode == 0) begin
            if (cmd_valid) begin
                armed = 1; ab = 0; mdir = cmd_dir; rem = int'(cmd_steps); t = 0;
                mode = cmd_steps == 16'd0 ? 2 : 1;
            end
        end else if (mode == 1) begin
            if (cmd_abort) begin
                ab = 1; mode = 2;
            end else begin
                t++;
                if (t % SD == 0) begin
                    ph = (ph + (mdir ? 1 : 3)) % 4;
                    pos = mdir ? pos + 16'd1 : pos - 16'd1;
                    rem--;
                    if (rem == 0) mode = 2;
                end
            end
        end else begin
            mode = 0;
        end
    endtask

    task automatic compare_all();
        chk("ready", 32'(rdy0), 32'(mode == 0));
        chk("busy", 32'(busy0), 32'(mode == 1));
        chk("done", 32'(done0), 32'(mode == 2));
        chk("aborted", 32'(ab0), 32'(ab));
        chk("steps_left", 32'(sl0), 32'(rem));
        chk("position", 32'(pos0), 32'(pos));
        chk("coils_hold", 32'(coils0), 32'((mode == 1 || armed) ? tbl[ph] : 4'b0000));
        chk("coils_nohold", 32'(coils1), 32'(mode == 1 ? tbl[ph] : 4'b0000));
        chk("done_nohold", 32'(done1), 32'(mode == 2));
    endtask

    task automatic step_cycle();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic cmd(input logic d, input logic [15:0] n);
        cmd_valid = 1'b1; cmd_dir = d; cmd_steps = n;
        step_cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_coils", 32'(coils0), 32'(0));
        chk("rst_busy", 32'(busy0), 32'(0));
        chk("rst_position", 32'(pos0), 32'(0));
        chk("rst_steps_left", 32'(sl0), 32'(0));
        #2;
        reset = 1'b1;
    endtask

    initial begin
        tbl[0] = 4'b0011; tbl[1] = 4'b0110; tbl[2] = 4'b1100; tbl[3] = 4'b1001;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        compare_all();
        chk("reset_coils", 32'(coils0), 32'(0));
        chk("reset_ready", 32'(rdy0), 32'(1));

        cmd(1'b1, 16'd5);
        run(24);
        chk("fwd5_position", 32'(pos0), 32'(5));
        chk("fwd5_coils", 32'(coils0), 32'(4'b0110));

        pulse_reset();
        cmd(1'b0, 16'd3);
        run(14);
        chk("rev3_position", 32'(pos0), 32'(16'hFFFD));
        chk("rev3_aborted", 32'(ab0), 32'(0));

        cmd(1'b1, 16'd0);
        chk("zero_done", 32'(done0), 32'(1));
        run(2);

        cmd(1'b1, 16'd3);
        run(14);
        chk("wrap_position", 32'(pos0), 32'(0));

        p0 = pos0;
        cmd(1'b1, 16'd10);
        run(11);
        cmd_abort = 1'b1;
        step_cycle();
        cmd_abort = 1'b0;
        chk("abort_position", 32'(pos0), 32'(p0 + 16'd2));
        chk("abort_steps_left", 32'(sl0), 32'(8));
        chk("abort_flag", 32'(ab0), 32'(1));
        step_cycle();
        cmd(1'b1, 16'd1);
        chk("abort_reaccept", 32'(busy0), 32'(1));
        run(6);

        cmd(1'b0, 16'd4);
        for (int i = 0; i < 20; i++) begin
            cmd_valid = 1'($urandom % 2);
            cmd_dir = 1'($urandom % 2);
            cmd_steps = 16'($urandom_range(0, 5));
            step_cycle();
        end
        cmd_valid = 1'b0;
        run(40);

        cmd(1'b1, 16'd6);
        run(7);
        pulse_reset();
        cmd(1'b1, 16'd1);
        run(6);
        chk("post_reset_position", 32'(pos0), 32'(1));

        for (int i = 0; i < 800; i++) begin
            cmd_valid = 1'($urandom % 2);
            cmd_dir = 1'($urandom % 2);
            cmd_steps = 16'($urandom_range(0, 6));
            cmd_abort = ($urandom % 16) == 0;
            step_cycle();
        end
        cmd_valid = 1'b0;
        cmd_abort = 1'b0;
        run(30);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/stepper_sequencer.md
# stepper_sequencer

Command-driven sequencer for the theta stepper motor. It accepts a direction and a step count from the processor-side register interface and drives the four coil outputs through a full-step two-phase sequence at a fixed, parameterised step rate. It tracks absolute position and reports busy, done and abort status back to software. It sits between the processor's memory-mapped control registers and the JA1–JA4 coil pins, and replaces free-running direction/enable control of the motor.

## Interface
- `STEP_DIV`, 50000: clock cycles per step (1 kHz at 50 MHz); legal range 2..2^20-1.
- `HOLD_EN`, 1: 1 = coils keep the last pattern while idle; 0 = coils de-energised (4'b0000) while idle.
- `clock`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE; a command is accepted on any cycle where `cmd_valid` and `cmd_ready` are both high.
- `cmd_dir`  in  1  1 = forward (phase increments, position +1); 0 = reverse.
- `cmd_steps`  in  16  number of steps to take, unsigned.
- `cmd_abort`  in  1  level; stops an in-progress move.
- `coils`  out  4  {JA4, JA3, JA2, JA1} drive.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a command finishes.
- `aborted`  out  1  valid with `done`; 1 if the command ended by abort.
- `steps_left`  out  16  remaining steps of the current command.
- `position`  out  16  absolute step count, two's complement, wraps modulo 2^16.

## Operation
- Phase table, indexed by the 2-bit `phase`: 0 = 4'b0011, 1 = 4'b0110, 2 = 4'b1100, 3 = 4'b1001.
- `phase` wraps 3→0 when moving forward and 0→3 when moving in reverse.
- States are IDLE, RUN and DONE.
- **IDLE**
  - `cmd_ready` = 1.
  - `coils` = table[`phase`] if `HOLD_EN`, otherwise 0.
  - On accept with `cmd_steps` = 0: go to DONE. No step is taken and `aborted` = 0.
  - On accept with `cmd_steps` ≠ 0: latch the direction, load `steps_left` = `cmd_steps`, clear the divider, go to RUN.
- **RUN**
  - `coils` = table[`phase`].
  - The divider counts 0..`STEP_DIV`-1. The cycle on which it reaches `STEP_DIV`-1 is a step tick.
  - On a tick: advance `phase`, `position` ±1, `steps_left` -1, divider → 0.
  - If `steps_left` becomes 0 on a tick, go to DONE with `aborted` = 0.
  - If `cmd_abort` is high in RUN, go to DONE with `aborted` = 1. No step is taken that cycle, even if it is a tick cycle (abort wins). `steps_left` keeps its remaining value.
  - `cmd_valid` is ignored in RUN.
- **DONE**
  - Lasts exactly one cycle with `done` = 1; then IDLE.
  - `coils` follow the same rule as in IDLE.
- `cmd_abort` is ignored in IDLE and DONE.
- `aborted` holds its value until the next accept, which clears it.
- `position` is never cleared except by reset.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE, `phase` = 0, divider = 0.
  - `coils` = 4'b0000 regardless of `HOLD_EN`, until the first command.
  - `cmd_ready` = 1 once reset deasserts; `busy` = 0, `done` = 0, `aborted` = 0.
  - `steps_left` = 0, `position` = 0.
- Reset asserted mid-move forces all outputs to their reset values immediately (asynchronous).
- Accept at edge k:
  - `busy` = 1 and `cmd_ready` = 0 from k+1.
  - `coils` = table[`phase`] from k+1.
  - First step takes effect at k+`STEP_DIV`; subsequent steps every `STEP_DIV` cycles.
- N-step command accepted at edge k:
  - Last step at k+N·`STEP_DIV`.
  - `done` high for the cycle after that edge.
  - `cmd_ready` = 1 at k+N·`STEP_DIV`+1.
- Zero-step command accepted at edge k: `done` high in cycle k+1; ready again at k+2.
- Abort sampled at edge j: state is DONE from j+1; ready again at j+2.
- `position` wraps: 16'h7FFF +1 = 16'h8000; 16'h0000 −1 = 16'hFFFF.

## Test plan
- Reset with `STEP_DIV`=4, `HOLD_EN`=1: `coils`=0, `cmd_ready`=1, `position`=0; then forward 5 steps → `coils` sequence 0011 (on accept), 0110, 1100, 1001, 0011, 0110 at 4-cycle spacing; `done` pulse once; `position`=5; `coils` hold 0110.
- Reverse 3 from `phase`=0: `coils` go 0011 (on accept), 1001, 1100, 0110; `position` 0 → 16'hFFFD; `aborted`=0.
- `cmd_steps`=0: `done` in the following cycle; no `coils` change; `position` unchanged.
- Forward 10, `cmd_abort` high on the cycle of the 3rd tick: `position`=2, `steps_left`=8, `done`=1, `aborted`=1; a new command is accepted 2 cycles later.
- `cmd_valid` toggled throughout a move: no second command is accepted until ready; `HOLD_EN`=0 variant shows `coils`=0 in IDLE and DONE.
- Reset asserted mid-move: `coils`=0, `busy`=0, `position`=0 immediately; a forward 1 step after release works normally.
